alu_cmd_sequencer: RTL

- Sequential front end for the 4-bit combinational ALU: issues operations to it and collects the results.
- Accepts one command per valid/ready handshake and drives the ALU operand/select inputs.
- Waits a programmable settle time, registers the ALU outputs, and returns them through a valid/ready response port.
- Replaces hand-written stimulus sequences so a controller or bus can run the ALU transaction by transaction.

---
 rtl/alu_cmd_sequencer_if.sv | 28 ++
 rtl/alu_cmd_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response bus between a controller and the ALU command sequencer.
// master = controller issuing commands, slave = the sequencer.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_op;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_flags;
    logic [CNT_W-1:0] done_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_flags, done_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_flags, done_cnt
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequential front end for the 4-bit combinational ALU: accepts one command,
// holds the ALU inputs for SETTLE cycles, captures the results and returns
// them over a valid/ready response port. One transaction in flight at a time.
module alu_cmd_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_sequencer_if.slave   bus,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic                 alu_s1,
    output logic                 alu_s0,
    input  logic [WIDTH-1:0]     alu_sum,
    input  logic                 alu_carry,
    input  logic                 alu_gt,
    input  logic                 alu_lt,
    input  logic                 alu_eq,
    input  logic [WIDTH-1:0]     alu_and
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("alu_cmd_sequencer: SETTLE must be in 1..15");
    end

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic [1:0]       rsp_op_q, rsp_op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    // Next-state and datapath: accept in IDLE, count down in DRIVE,
    // capture on the last settle cycle, hold the response until consumed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_op_d    = rsp_op_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        done_cnt_d  = done_cnt_q;

        case (state_q)
            IDLE: begin
                // cmd_ready_q gates acceptance so nothing is taken on the
                // first edge after reset release.
                if (bus.cmd_valid && cmd_ready_q) begin
                    alu_a_d   = bus.cmd_a;
                    alu_b_d   = bus.cmd_b;
                    alu_sel_d = bus.cmd_op;
                    cnt_d     = SETTLE_L;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_op_d    = alu_sel_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                    case (alu_sel_q)
                        2'b00, 2'b01: begin
                            rsp_data_d  = alu_sum;
                            rsp_flags_d = {alu_carry, 3'b000};
                        end
                        2'b10: begin
                            rsp_data_d  = '0;
                            rsp_flags_d = {1'b0, alu_gt, alu_lt, alu_eq};
                        end
                        default: begin
                            rsp_data_d  = alu_and;
                            rsp_flags_d = 4'b0000;
                        end
                    endcase
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_op_q    <= rsp_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_op    = rsp_op_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.done_cnt  = done_cnt_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_s1        = alu_sel_q[1];
    assign alu_s0        = alu_sel_q[0];

endmodule
